// File: rtl/bcd_display_scan.sv
// -----------------------------------------------------------------------------
// bcd_display_scan
//
// Time-multiplexes a two-digit BCD value (tens/ones from the balance counter)
// onto a 2-digit common-anode seven-segment display. Each digit slot opens
// with an all-anodes-off blank to stop ghosting between digits. A leading
// tens zero can be suppressed, and the whole display can be flashed in
// frame-sized half-periods (used when the balance has saturated).
//
// Ports:
//   i_clk          system clock, rising edge
//   i_rst_n        asynchronous active-low reset
//   i_tens         BCD tens digit
//   i_ones         BCD ones digit
//   i_flash        level; when high the display blinks
//   o_seg          active-low segments, o_seg[0]=a ... o_seg[6]=g
//   o_an           active-low anodes, o_an[0]=ones, o_an[1]=tens
//   o_frame_start  one-cycle pulse in the first cycle of every frame
//
// state      | meaning
// -----------+----------------------------------------------------------
// BLANK_ONES | anodes off before the ones digit; frame starts here
// SHOW_ONES  | ones digit lit (unless the flash phase is dark)
// BLANK_TENS | anodes off before the tens digit
// SHOW_TENS  | tens digit lit (unless dark or a suppressed leading zero)
// -----------------------------------------------------------------------------
module bcd_display_scan #(
    parameter int SCAN_CYCLES        = 50000,
    parameter int BLANK_CYCLES       = 1000,
    parameter int BLANK_LEADING_ZERO = 1,
    parameter int FLASH_FRAMES       = 32
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [3:0] i_tens,
    input  logic [3:0] i_ones,
    input  logic       i_flash,
    output logic [6:0] o_seg,
    output logic [1:0] o_an,
    output logic       o_frame_start
);

    localparam int CW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int FW = (FLASH_FRAMES > 1) ? $clog2(FLASH_FRAMES) : 1;

    localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);
    localparam logic [CW-1:0] SLOT_LAST  = CW'(SCAN_CYCLES - 1);
    localparam logic [FW-1:0] FLASH_LAST = FW'(FLASH_FRAMES - 1);

    localparam logic [6:0] SEG_OFF = 7'h7F;
    localparam logic [1:0] AN_OFF  = 2'b11;
    localparam logic [1:0] AN_ONES = 2'b10;
    localparam logic [1:0] AN_TENS = 2'b01;

    typedef enum logic [1:0] {
        BLANK_ONES = 2'd0,
        SHOW_ONES  = 2'd1,
        BLANK_TENS = 2'd2,
        SHOW_TENS  = 2'd3
    } state_t;

    state_t          r_state;
    logic [CW-1:0]   r_cnt;
    logic [3:0]      r_tens;
    logic [3:0]      r_ones;
    logic [FW-1:0]   r_fcnt;
    logic            r_phase;
    logic            r_lit;
    logic            r_started;

    logic            w_capture;
    logic            w_tens_lit;
    logic            w_lead_zero;

    // Active-low decode, bit order {g,f,e,d,c,b,a}; non-BCD codes show a dash.
    function automatic logic [6:0] f_decode(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;
        endcase
        return s;
    endfunction

    // The first edge after reset release is treated like a frame wrap so the
    // display always starts from a fresh capture.
    assign w_capture   = !r_started || ((r_state == SHOW_TENS) && (r_cnt == SLOT_LAST));
    assign w_lead_zero = (BLANK_LEADING_ZERO != 0) && (r_tens == 4'd0);
    assign w_tens_lit  = r_lit && !w_lead_zero;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_state       <= BLANK_ONES;
            r_cnt         <= '0;
            r_tens        <= 4'd0;
            r_ones        <= 4'd0;
            r_fcnt        <= '0;
            r_phase       <= 1'b1;
            r_lit         <= 1'b1;
            r_started     <= 1'b0;
            o_an          <= AN_OFF;
            o_seg         <= SEG_OFF;
            o_frame_start <= 1'b0;
        end else begin
            o_frame_start <= 1'b0;

            if (!r_started) begin
                // Hold at BLANK_ONES / count 0; this edge opens the first frame.
                r_started <= 1'b1;
            end else begin
                r_cnt <= (r_cnt == SLOT_LAST) ? '0 : r_cnt + CW'(1);
                case (r_state)
                    BLANK_ONES: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= SHOW_ONES;
                            o_an    <= r_lit ? AN_ONES : AN_OFF;
                            o_seg   <= r_lit ? f_decode(r_ones) : SEG_OFF;
                        end
                    end
                    SHOW_ONES: begin
                        if (r_cnt == SLOT_LAST) begin
                            r_state <= BLANK_TENS;
                            o_an    <= AN_OFF;
                            o_seg   <= SEG_OFF;
                        end
                    end
                    BLANK_TENS: begin
                        if (r_cnt == BLANK_LAST) begin
                            r_state <= SHOW_TENS;
                            o_an    <= w_tens_lit ? AN_TENS : AN_OFF;
                            o_seg   <= w_tens_lit ? f_decode(r_tens) : SEG_OFF;
                        end
                    end
                    SHOW_TENS: begin
                        if (r_cnt == SLOT_LAST) begin
                            r_state <= BLANK_ONES;
                            o_an    <= AN_OFF;
                            o_seg   <= SEG_OFF;
                        end
                    end
                    default: begin
                        r_state <= BLANK_ONES;
                        o_an    <= AN_OFF;
                        o_seg   <= SEG_OFF;
                    end
                endcase
            end

            if (w_capture) begin
                r_tens        <= i_tens;
                r_ones        <= i_ones;
                o_frame_start <= 1'b1;
                // r_phase is the phase of the next flashing frame; r_lit is
                // the phase frozen for the frame that starts now.
                if (i_flash) begin
                    r_lit <= r_phase;
                    if (r_fcnt == FLASH_LAST) begin
                        r_fcnt  <= '0;
                        r_phase <= ~r_phase;
                    end else begin
                        r_fcnt <= r_fcnt + FW'(1);
                    end
                end else begin
                    r_lit   <= 1'b1;
                    r_phase <= 1'b1;
                    r_fcnt  <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_bcd_display_scan.sv
// -----------------------------------------------------------------------------
// tb_bcd_display_scan
//
// Two instances share stimulus: u_dut1 suppresses a leading tens zero,
// u_dut0 does not. A frame-position model predicts every output each cycle;
// directed literal checks pin the model at key points.
// -----------------------------------------------------------------------------
module tb_bcd_display_scan;

    localparam int SCAN  = 8;
    localparam int BLANK = 2;
    localparam int FF    = 2;
    localparam int FRAME = 2 * SCAN;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [3:0] tens = 4'd0;
    logic [3:0] ones = 4'd0;
    logic       flash = 1'b0;

    logic [6:0] seg1, seg0;
    logic [1:0] an1, an0;
    logic       fs1, fs0;

    int n_pass = 0;
    int n_total = 0;

    // model state
    int         m_pos = -1;
    int         m_fk = -1;
    logic       m_lit = 1'b1;
    logic [3:0] m_tens = 4'd0;
    logic [3:0] m_ones = 4'd0;

    always #5 clk = ~clk;

    bcd_display_scan #(
        .SCAN_CYCLES(SCAN), .BLANK_CYCLES(BLANK),
        .BLANK_LEADING_ZERO(1), .FLASH_FRAMES(FF)
    ) u_dut1 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tens(tens), .i_ones(ones),
        .i_flash(flash), .o_seg(seg1), .o_an(an1), .o_frame_start(fs1)
    );

    bcd_display_scan #(
        .SCAN_CYCLES(SCAN), .BLANK_CYCLES(BLANK),
        .BLANK_LEADING_ZERO(0), .FLASH_FRAMES(FF)
    ) u_dut0 (
        .i_clk(clk), .i_rst_n(rst_n), .i_tens(tens), .i_ones(ones),
        .i_flash(flash), .o_seg(seg0), .o_an(an0), .o_frame_start(fs0)
    );

    function automatic logic [6:0] dec(input logic [3:0] d);
        case (d)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b at %0t", name, got, exp, $time);
    endtask

    // Frame-level model: position in frame, shadow digits, flash frame index.
    always @(posedge clk) begin
        if (!rst_n) begin
            m_pos = -1;
            m_fk  = -1;
            m_lit = 1'b1;
        end else if (m_pos < 0 || m_pos == FRAME - 1) begin
            m_pos  = 0;
            m_tens = tens;
            m_ones = ones;
            if (flash) m_fk = m_fk + 1;
            else       m_fk = -1;
            m_lit = (m_fk < 0) || (((m_fk / FF) % 2) == 0);
        end else begin
            m_pos = m_pos + 1;
        end
    end

    task automatic expect_out(input int blz, output logic [1:0] an,
                              output logic [6:0] seg, output logic fs);
        int slot, off;
        an = 2'b11; seg = 7'h7F; fs = 1'b0;
        if (rst_n && m_pos >= 0) begin
            fs   = (m_pos == 0);
            slot = m_pos / SCAN;
            off  = m_pos % SCAN;
            if (off >= BLANK && m_lit) begin
                if (slot == 0) begin
                    an = 2'b10; seg = dec(m_ones);
                end else if (!(blz != 0 && m_tens == 4'd0)) begin
                    an = 2'b01; seg = dec(m_tens);
                end
            end
        end
    endtask

    always @(negedge clk) begin
        logic [1:0] ea;
        logic [6:0] es;
        logic       ef;
        if ($time > 3) begin
            expect_out(1, ea, es, ef);
            chk("model_an_blz1", {6'd0, an1}, {6'd0, ea});
            chk("model_seg_blz1", {1'b0, seg1}, {1'b0, es});
            chk("model_fs_blz1", {7'd0, fs1}, {7'd0, ef});
            expect_out(0, ea, es, ef);
            chk("model_an_blz0", {6'd0, an0}, {6'd0, ea});
            chk("model_seg_blz0", {1'b0, seg0}, {1'b0, es});
            chk("model_fs_blz0", {7'd0, fs0}, {7'd0, ef});
        end
    end

    task automatic wait_pos(input int p);
        int n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (m_pos != p && n < 40);
        if (m_pos != p) begin
            n_total++;
            $display("FAIL wait_pos: position %0d not reached (at %0d)", p, m_pos);
        end
    endtask

    initial begin
        logic [1:0] flash_an [4];
        flash_an[0] = 2'b10; flash_an[1] = 2'b10;
        flash_an[2] = 2'b11; flash_an[3] = 2'b11;

        // reset with tens=4, ones=7
        tens = 4'd4; ones = 4'd7; flash = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("reset_an", {6'd0, an1}, 8'b11);
        chk("reset_seg", {1'b0, seg1}, 8'h7F);
        chk("reset_fs", {7'd0, fs1}, 8'd0);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("first_fs", {7'd0, fs1}, 8'd1);
        chk("first_blank_an", {6'd0, an1}, 8'b11);
        @(negedge clk);
        chk("fs_once", {7'd0, fs1}, 8'd0);
        chk("blank2_an", {6'd0, an1}, 8'b11);
        @(negedge clk);
        chk("ones7_an", {6'd0, an1}, 8'b10);
        chk("ones7_seg", {1'b0, seg1}, {1'b0, 7'b1111000});
        wait_pos(10);
        chk("tens4_an", {6'd0, an1}, 8'b01);
        chk("tens4_seg", {1'b0, seg1}, {1'b0, 7'b0011001});
        wait_pos(0);
        chk("frame2_fs", {7'd0, fs1}, 8'd1);

        // leading zero, both variants
        tens = 4'd0; ones = 4'd3;
        wait_pos(0);
        wait_pos(4);
        chk("ones3_seg", {1'b0, seg1}, {1'b0, 7'b0110000});
        wait_pos(12);
        chk("lz_blz1_an", {6'd0, an1}, 8'b11);
        chk("lz_blz1_seg", {1'b0, seg1}, 8'h7F);
        chk("lz_blz0_an", {6'd0, an0}, 8'b01);
        chk("lz_blz0_seg", {1'b0, seg0}, {1'b0, 7'b1000000});

        // mid-frame change appears next frame
        tens = 4'd1; ones = 4'd5;
        wait_pos(0);
        wait_pos(4);
        tens = 4'd9;
        wait_pos(12);
        chk("tens_old_seg", {1'b0, seg1}, {1'b0, 7'b1111001});
        wait_pos(12);
        chk("tens_new_seg", {1'b0, seg1}, {1'b0, 7'b0010000});

        // non-BCD ones
        ones = 4'd12;
        wait_pos(4);
        chk("dash_seg", {1'b0, seg1}, {1'b0, 7'b0111111});

        // flash: lit, lit, dark, dark, then release
        tens = 4'd9; ones = 4'd9;
        wait_pos(8);
        flash = 1'b1;
        for (int i = 0; i < 4; i++) begin
            wait_pos(4);
            chk($sformatf("flash_f%0d_an", i), {6'd0, an1}, {6'd0, flash_an[i]});
            if (i == 2) chk("flash_dark_seg", {1'b0, seg1}, 8'h7F);
        end
        flash = 1'b0;
        wait_pos(4);
        chk("unflash_an", {6'd0, an1}, 8'b10);
        chk("unflash_seg", {1'b0, seg1}, {1'b0, 7'b0010000});
        wait_pos(12);
        chk("unflash_tens_an", {6'd0, an1}, 8'b01);

        // async reset during SHOW_TENS
        wait_pos(12);
        #2 rst_n = 1'b0;
        #1;
        chk("async_an", {6'd0, an1}, 8'b11);
        chk("async_seg", {1'b0, seg1}, 8'h7F);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("restart_fs", {7'd0, fs1}, 8'd1);
        wait_pos(2);
        chk("restart_an", {6'd0, an1}, 8'b10);
        chk("restart_seg", {1'b0, seg1}, {1'b0, 7'b0010000});
        repeat (20) @(negedge clk);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule

// File: doc/bcd_display_scan.md
Name: bcd_display_scan

Overview:
- Downstream consumer of the two-digit BCD balance counter (tens digit, ones digit, saturating at 99).
- Time-multiplexes both digits onto a 2-digit common-anode seven-segment display.
- Per-digit anti-ghosting blank, optional leading-zero suppression, and a frame-synchronous flash used when the balance is saturated.

Parameters:
- SCAN_CYCLES, 50000, clock cycles per digit slot including blank; legal range BLANK_CYCLES < SCAN_CYCLES.
- BLANK_CYCLES, 1000, cycles at the start of each slot with all anodes off; must be >= 1.
- BLANK_LEADING_ZERO, 1, when 1 a tens digit of 0 is not lit.
- FLASH_FRAMES, 32, frames per flash half-period; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- tens  in  4  BCD tens digit from the balance counter.
- ones  in  4  BCD ones digit from the balance counter.
- flash  in  1  level; when high the display blinks.
- seg  out  7  active-low segments; seg[0]=a ... seg[6]=g.
- an  out  2  active-low anodes; an[0]=ones, an[1]=tens.
- frame_start  out  1  one-cycle pulse at the start of each frame.

Behaviour:
- Reset (async, rst_n=0): outputs forced immediately, no clock needed.
  - an=2'b11, seg=7'h7F, frame_start=0.
  - state=BLANK_ONES, slot counter=0, shadow digits=0, flash counter=0, flash phase=ON.
- FSM: BLANK_ONES -> SHOW_ONES -> BLANK_TENS -> SHOW_TENS -> BLANK_ONES.
  - Each BLANK state lasts BLANK_CYCLES cycles.
  - Each SHOW state lasts SCAN_CYCLES-BLANK_CYCLES cycles.
  - One frame is 2*SCAN_CYCLES cycles.
- Capture edge is the first active edge after reset release and every SHOW_TENS->BLANK_ONES edge. On it:
  - tens and ones are latched into shadow registers.
  - flash is sampled.
  - frame_start=1 for exactly the following cycle.
- Display uses shadow values only. Input changes mid-frame appear from the next frame.
- seg and an are registered and change on the edge that enters the state.
  - BLANK states: an=2'b11, seg=7'h7F.
  - SHOW_ONES: an=2'b10.
  - SHOW_TENS: an=2'b01.
- Decode (active-low, {g..a}):
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001.
  - 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
  - Values 10-15 show a dash, 0111111.
- Leading zero: with BLANK_LEADING_ZERO=1 and shadow tens==0, SHOW_TENS drives an=2'b11, seg=7'h7F. The ones digit is always shown.
- Flash, evaluated per frame:
  - If sampled flash=0: flash counter=0, phase=ON.
  - If sampled flash=1: counter increments each frame. Phase toggles and counter clears when the counter reaches FLASH_FRAMES-1.
  - The first flashing frame has phase ON.
  - While phase is OFF, both SHOW states drive an=2'b11 and seg=7'h7F for the whole frame.
- Slot counter is width clog2(SCAN_CYCLES). It wraps to 0 at each slot boundary with no extra cycle.
- Reset asserted mid-frame: immediate blank. After release, a new frame starts with a fresh capture.

Test Plan (SCAN_CYCLES=8, BLANK_CYCLES=2, FLASH_FRAMES=2 unless stated):
- Apply tens=4, ones=7; release reset -> frame_start pulses once; frame repeats every 16 cycles.
  - an=11 for 2 cycles, then an=10 with seg=1111000 for 6 cycles.
  - Then an=11 for 2 cycles, then an=01 with seg=0011001 for 6 cycles.
- tens=0, ones=3, BLANK_LEADING_ZERO=1 -> tens slot holds an=11 for all 8 cycles; ones slot shows seg=0110000.
  - Repeat with BLANK_LEADING_ZERO=0 -> tens slot shows seg=1000000, an=01.
- tens=1; change tens to 9 during SHOW_ONES -> tens slot shows 1111001 this frame, 0010000 from the next frame.
- ones=12 -> ones slot shows dash 0111111.
- tens=9, ones=9, flash=1 held -> frames lit, lit, dark, dark, lit, ...
  - Deasserting flash restores the lit display at the next frame.
- Pulse rst_n low for 3 cycles during SHOW_TENS -> an=11 and seg=7F at once, asynchronously.
  - After release, frame_start pulses and the sequence restarts at BLANK_ONES.
